// File: rtl/cim_pkg.sv
// cim_pkg: shared defaults and FSM state encoding for the CIM adder-tree feeder
package cim_pkg;

    localparam int DEF_N_IN    = 32;
    localparam int DEF_W_IN    = 4;
    localparam int DEF_W_OUT   = 13;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/cim_feeder_if.sv
// cim_feeder_if: operand stream, adder-tree and result handshakes of the feeder
interface cim_feeder_if
    import cim_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int W_IN  = DEF_W_IN,
    parameter int W_OUT = DEF_W_OUT
);

    logic                   in_valid;
    logic [W_IN-1:0]        in_data;
    logic                   in_ready;
    logic [N_IN*W_IN-1:0]   tree_in;
    logic                   tree_start;
    logic                   tree_out_valid;
    logic [W_OUT-1:0]       tree_out;
    logic                   res_valid;
    logic [W_OUT-1:0]       res_data;
    logic                   res_ready;
    logic                   timeout_err;

    modport master (
        output in_valid, in_data, tree_out_valid, tree_out, res_ready,
        input  in_ready, tree_in, tree_start, res_valid, res_data, timeout_err
    );

    modport slave (
        input  in_valid, in_data, tree_out_valid, tree_out, res_ready,
        output in_ready, tree_in, tree_start, res_valid, res_data, timeout_err
    );

endinterface

// File: rtl/cim_feeder.sv
// cim_feeder: gathers N_IN operands, issues them to an adder tree and holds its result
module cim_feeder
    import cim_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int W_IN    = DEF_W_IN,
    parameter int W_OUT   = DEF_W_OUT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic      clk,
    input  logic      rst_n,
    cim_feeder_if.slave bus
);

    localparam int CW = $clog2(N_IN);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt;
    logic [TW-1:0]          wcnt;
    logic [W_IN-1:0]        opnd [N_IN];
    logic [N_IN*W_IN-1:0]   packed_q;
    logic [W_OUT-1:0]       res_q;
    logic                   err_q;
    logic                   rdy, start, rvld, hs, last, tmo, cap;

    assign hs   = bus.in_valid && rdy;
    assign last = cnt == CW'(N_IN - 1);
    assign tmo  = wcnt == TW'(TIMEOUT - 1);
    assign cap  = bus.tree_out_valid && (state == ISSUE || state == WAIT);

    // next state and the state-decoded handshake outputs
    always_comb begin
        rdy      = rst_n && state == LOAD;
        start    = rst_n && state == ISSUE;
        rvld     = rst_n && state == RESULT;
        state_nx = state;
        case (state)
            LOAD:    state_nx = (bus.in_valid && rdy && last) ? ISSUE : LOAD;
            ISSUE:   state_nx = bus.tree_out_valid ? RESULT : WAIT;
            WAIT:    state_nx = bus.tree_out_valid ? RESULT : (tmo ? LOAD : WAIT);
            RESULT:  state_nx = (rvld && bus.res_ready) ? LOAD : RESULT;
            default: state_nx = LOAD;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    // operand buffer, counters, captured result and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            wcnt  <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < N_IN; k++) opnd[k] <= '0;
        end else begin
            if (hs) begin
                opnd[cnt] <= bus.in_data;
                cnt       <= last ? '0 : cnt + 1'b1;
            end
            wcnt <= (state == WAIT && state_nx == WAIT) ? wcnt + 1'b1 : '0;
            if (cap) res_q <= bus.tree_out;
            if (state == WAIT && !bus.tree_out_valid && tmo) err_q <= 1'b1;
            else if (hs)                                     err_q <= 1'b0;
        end
    end

    // slot k drives tree input k+1; bits pass through untouched
    always_comb begin
        packed_q = '0;
        for (int k = 0; k < N_IN; k++) packed_q[k*W_IN +: W_IN] = opnd[k];
    end

    assign bus.in_ready    = rdy;
    assign bus.tree_start  = start;
    assign bus.tree_in     = packed_q;
    assign bus.res_valid   = rvld;
    assign bus.res_data    = res_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_cim_feeder.sv
// tb_cim_feeder: table-driven and randomized checks of the feeder against a transaction model
module tb_cim_feeder;
    import cim_pkg::*;

    localparam int N  = 32;
    localparam int WI = 4;
    localparam int WO = 13;
    localparam int TO = 64;

    typedef struct {
        int pat;
        int gap;
        int ret;
        int lat;
        int stall;
        int exp_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_hs = 0;
    int   n_start = 0;
    logic [WI-1:0] ops [N];
    logic [WO-1:0] prev_res = '0;
    logic          exp_err = 1'b0;
    vec_t tbl [5];

    cim_feeder_if #(.N_IN(N), .W_IN(WI), .W_OUT(WO)) bus ();

    cim_feeder #(.N_IN(N), .W_IN(WI), .W_OUT(WO), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) n_hs++;
        if (bus.tree_start) n_start++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [N*WI-1:0] act, input logic [N*WI-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < N; k++)
            ops[k] = pat == 0 ? 4'hf : pat == 1 ? WI'(k % 16) : pat == 2 ? 4'h1 : WI'($urandom);
    endtask

    task automatic run_vec(input int gap, input int ret, input int lat, input int stall, input int exp_val);
        int k, guard, bad, hs0, st0, sum, rv;
        logic v, tog;
        logic [N*WI-1:0] exp_tree;
        for (int i = 0; i < N; i++) exp_tree[i*WI +: WI] = ops[i];
        chk("err_before_load", bus.timeout_err, exp_err);
        hs0 = n_hs;
        st0 = n_start;
        k = 0;
        guard = 0;
        bad = 0;
        tog = 1'b1;
        while (k < N && guard < 4000) begin
            v = gap < 0 ? tog : ($urandom_range(99) >= gap);
            tog = ~tog;
            bus.in_valid = v;
            bus.in_data = ops[k];
            bus.tree_out_valid = $urandom_range(3) == 0;
            bus.tree_out = WO'($urandom);
            if (!bus.in_ready) bad++;
            @(posedge clk); #1;
            guard++;
            if (v) k++;
            if (v && k == 1) chk("err_clear_on_hs", bus.timeout_err, 0);
        end
        bus.in_valid = 1'b0;
        bus.tree_out_valid = 1'b0;
        chk("load_count", k, N);
        chk("ready_during_load", bad, 0);
        exp_err = 1'b0;
        chk("in_ready_issue", bus.in_ready, 0);
        chk("tree_start_issue", bus.tree_start, 1);
        chk("tree_in", bus.tree_in, exp_tree);
        chk("res_data_held", bus.res_data, prev_res);
        chk("handshakes", n_hs - hs0, N);
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(bus.tree_in[i*WI +: WI]);
        rv = ret < 0 ? sum : ret;
        if (lat == -2) begin
            repeat (5) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("rst_wait_res_valid", bus.res_valid, 0);
            chk("rst_wait_tree_in", bus.tree_in, 0);
            rst_n = 1'b1;
            repeat (TO + 4) @(posedge clk);
            #1;
            chk("rst_wait_err", bus.timeout_err, 0);
            chk("rst_wait_ready", bus.in_ready, 1);
            prev_res = '0;
        end else if (lat < 0) begin
            for (int c = 0; c < TO; c++) begin
                @(posedge clk); #1;
                if (bus.timeout_err || bus.in_ready || bus.res_valid) bad++;
            end
            chk("wait_quiet", bad, 0);
            @(posedge clk); #1;
            chk("timeout_err_set", bus.timeout_err, 1);
            chk("timeout_to_load", bus.in_ready, 1);
            chk("timeout_no_result", bus.res_valid, 0);
            chk("timeout_one_start", n_start - st0, 1);
            exp_err = 1'b1;
        end else begin
            for (int c = 0; c < lat; c++) begin
                @(posedge clk); #1;
                if (bus.res_valid || bus.in_ready) bad++;
            end
            bus.tree_out_valid = 1'b1;
            bus.tree_out = WO'(rv);
            @(posedge clk); #1;
            bus.tree_out_valid = 1'b0;
            chk("wait_quiet", bad, 0);
            chk("res_valid", bus.res_valid, 1);
            chk("res_data", bus.res_data, exp_val);
            for (int s = 0; s < stall; s++) begin
                bus.tree_out_valid = s[0] == 1'b0;
                bus.tree_out = 13'd7;
                @(posedge clk); #1;
                if (bus.res_data !== WO'(exp_val) || !bus.res_valid || bus.in_ready) bad++;
            end
            bus.tree_out_valid = 1'b0;
            chk("result_stall", bad, 0);
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
            chk("res_valid_drop", bus.res_valid, 0);
            chk("ready_after_result", bus.in_ready, 1);
            chk("res_data_after", bus.res_data, exp_val);
            chk("one_start", n_start - st0, 1);
            prev_res = WO'(exp_val);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.tree_out_valid = 1'b0;
        bus.tree_out = '0;
        bus.res_ready = 1'b0;
        tbl[0] = '{0, 0, -1, 3, 0, 480};
        tbl[1] = '{1, -1, -1, 2, 0, 240};
        tbl[2] = '{3, 0, 123, 1, 10, 123};
        tbl[3] = '{3, 20, 0, -1, 0, 0};
        tbl[4] = '{2, 0, 100, 0, 2, 100};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_tree_start", bus.tree_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_tree_in", bus.tree_in, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", bus.in_ready, 1);
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].pat);
            run_vec(tbl[t].gap, tbl[t].ret, tbl[t].lat, tbl[t].stall, tbl[t].exp_val);
        end

        fill(0);
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = ops[k];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midload_rst_ready", bus.in_ready, 0);
        chk("midload_rst_tree_in", bus.tree_in, 0);
        chk("midload_rst_res_data", bus.res_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        prev_res = '0;
        exp_err = 1'b0;
        fill(2);
        run_vec(0, -1, 2, 0, 32);

        fill(3);
        run_vec(0, 0, -2, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int sum, lat;
            fill(3);
            sum = 0;
            for (int k = 0; k < N; k++) sum += int'(ops[k]);
            lat = $urandom_range(7) == 0 ? -1 : int'($urandom_range(6));
            run_vec(int'($urandom_range(60)), -1, lat, int'($urandom_range(4)), sum);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_feeder.md
CIM_FEEDER -- requirements
Module: cim_feeder

Interface
REQ-001 The block SHALL have parameter N_IN, default 32, the number of adder-tree operands per vector.
REQ-002 The block SHALL have parameter W_IN, default 4, the operand width in bits.
REQ-003 The block SHALL have parameter W_OUT, default 13, the adder-tree result width in bits.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for the tree result.
REQ-005 clk  input  1  the single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  an operand is offered on in_data.
REQ-008 in_data  input  W_IN  operand value, unsigned.
REQ-009 in_ready  output  1  the block accepts an operand this cycle.
REQ-010 tree_in  output  N_IN*W_IN  packed operands; Input_k of the tree maps to bits [k*W_IN-1 : (k-1)*W_IN].
REQ-011 tree_start  output  1  one-cycle pulse marking that tree_in is valid.
REQ-012 tree_out_valid  input  1  adder-tree out_valid.
REQ-013 tree_out  input  W_OUT  adder-tree Output.
REQ-014 res_valid  output  1  a captured result is available.
REQ-015 res_data  output  W_OUT  captured result.
REQ-016 res_ready  input  1  the consumer accepts the result.
REQ-017 timeout_err  output  1  sticky flag; the last vector produced no tree result within TIMEOUT cycles.

Function
REQ-018 The FSM SHALL have the states LOAD, ISSUE, WAIT and RESULT; after reset it is in LOAD.
REQ-019 In LOAD: in_ready=1; each in_valid&&in_ready handshake writes in_data to slot cnt, then cnt increments.
REQ-020 Slot 0 SHALL be Input_1, i.e. the first accepted operand occupies tree_in[W_IN-1:0].
REQ-021 On the handshake with cnt=N_IN-1 the FSM SHALL go to ISSUE and cnt SHALL wrap to 0; in_ready is 0 in the next cycle.
REQ-022 In ISSUE: tree_start=1 for exactly one cycle, then go to WAIT; tree_in SHALL hold stable from ISSUE until the FSM re-enters LOAD.
REQ-023 In ISSUE or WAIT, tree_out_valid=1 SHALL capture tree_out into res_data and go to RESULT; tree_out_valid in ISSUE is legal and accepted.
REQ-024 In WAIT, a wait counter SHALL count cycles; if it reaches TIMEOUT with no tree_out_valid, set timeout_err, leave res_valid=0 and return to LOAD.
REQ-025 tree_out_valid in LOAD or RESULT SHALL be ignored and SHALL NOT alter res_data.
REQ-026 In RESULT: res_valid=1 and res_data stays stable until res_valid&&res_ready; on that cycle go to LOAD with in_ready=1 in the next cycle.
REQ-027 The minimum loop is N_IN load cycles + 1 ISSUE + tree latency + 1 RESULT cycle; there is no overlap of load and wait.
REQ-028 timeout_err SHALL clear on the first LOAD handshake of the next vector.
REQ-029 in_data values SHALL pass through to tree_in unmodified, with no sign extension or arithmetic.

Reset
REQ-030 When rst_n=0 at a rising edge: state=LOAD, cnt=0, wait counter=0, tree_in=0, tree_start=0, res_valid=0, res_data=0, timeout_err=0, in_ready=0 in that cycle.
REQ-031 A reset asserted mid-load or mid-wait SHALL discard the partial vector and any pending result.

Structure
REQ-032 N_IN, W_IN, W_OUT, TIMEOUT defaults and the state encoding SHALL live in the shared package cim_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the operand buffer is a register array inside it.
REQ-034 cnt SHALL be $clog2(N_IN) bits and the wait counter $clog2(TIMEOUT+1) bits.

Verification
REQ-035 Load 32 operands of value 15 and have the tree model return 480 after 3 cycles -> one tree_start pulse; res_valid with res_data=480.
REQ-036 Load operands 0..31 mod 16, with in_valid toggled every other cycle -> slot k equals k mod 16 on tree_in; exactly 32 handshakes, then in_ready=0.
REQ-037 Hold res_ready=0 for 10 cycles in RESULT while the tree pulses out_valid with 7 -> res_data stays at the original value; in_ready=0 throughout.
REQ-038 The tree model never responds -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, then state LOAD; the flag clears on the next handshake.
REQ-039 Assert rst_n=0 after 20 operands, then load a full vector of 1s -> tree_in is all 1s, tree_start pulses once, and no stale operands remain.
REQ-040 The tree model returns out_valid in the ISSUE cycle with value 100 -> res_valid on the next cycle with res_data=100.
